// File: rtl/phys_free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phys_free_list_pkg
// Brief    : Shared widths, tag/pointer types and index helper for the free list
// Revision : 1.0
// ============================================================================
package phys_free_list_pkg;

    localparam int PTAG_W   = 6;
    localparam int AREG_W   = 5;
    localparam int FL_DEPTH = 32;

    typedef logic [PTAG_W-1:0] ptag_t;
    // Index in the low bits, wrap bit on top to tell full from empty.
    typedef logic [AREG_W:0]   fl_ptr_t;

    function automatic logic [AREG_W-1:0] fl_idx(input fl_ptr_t p);
        return p[AREG_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/phys_free_list_if.sv
`default_nettype none
// ============================================================================
// Module   : phys_free_list_if
// Brief    : Rename/retire side handshake bundle of the physical free list
// Revision : 1.0
// ============================================================================
interface phys_free_list_if;
    import phys_free_list_pkg::*;

    logic    stall;
    logic    alloc_req;
    ptag_t   alloc_tag;
    logic    alloc_valid;
    logic    commit_alloc;
    logic    free_en;
    ptag_t   free_tag;
    logic    flush;
    fl_ptr_t free_count;
    logic    overflow_err;

    modport master (
        output stall, alloc_req, commit_alloc, free_en, free_tag, flush,
        input  alloc_tag, alloc_valid, free_count, overflow_err
    );

    modport slave (
        input  stall, alloc_req, commit_alloc, free_en, free_tag, flush,
        output alloc_tag, alloc_valid, free_count, overflow_err
    );

endinterface
`default_nettype wire

// File: rtl/phys_free_list_fl_ptr_ctr.sv
`default_nettype none
// ============================================================================
// Module   : fl_ptr_ctr
// Brief    : Wrap-bit FIFO pointer with increment enable and synchronous load
// Revision : 1.0
// ============================================================================
module fl_ptr_ctr
    import phys_free_list_pkg::*;
#(
    parameter fl_ptr_t RESET_VAL = '0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    input  wire logic    i_inc,
    input  wire logic    i_load,
    input  wire fl_ptr_t i_load_val,
    output fl_ptr_t      o_ptr
);

    fl_ptr_t r_ptr;
    fl_ptr_t w_ptr_next;

    // Load wins over increment; modulo-64 wrap falls out of the 6-bit add.
    always_comb begin
        w_ptr_next = r_ptr;
        if (i_load) begin
            w_ptr_next = i_load_val;
        end else if (i_inc) begin
            w_ptr_next = r_ptr + fl_ptr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= RESET_VAL;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/phys_free_list.sv
`default_nettype none
// ============================================================================
// Module   : phys_free_list
// Brief    : Circular free list of physical tags with speculative/committed heads
// Revision : 1.0
// ============================================================================
module phys_free_list
    import phys_free_list_pkg::*;
#(
    parameter int PREGS = 64,
    parameter int AREGS = 32
) (
    input  wire logic       clk,
    input  wire logic       reset,
    phys_free_list_if.slave fl
);

    localparam fl_ptr_t c_fl_depth = fl_ptr_t'(PREGS - AREGS);

    ptag_t   r_entry [FL_DEPTH];
    logic    r_overflow;

    fl_ptr_t w_spec_head;
    fl_ptr_t w_commit_head;
    fl_ptr_t w_commit_next;
    fl_ptr_t w_tail;
    fl_ptr_t w_commit_occ;
    logic    w_alloc_valid;
    logic    w_alloc_fire;
    logic    w_push_ok;
    logic    w_push;

    assign w_alloc_valid = (w_tail != w_spec_head);
    assign w_alloc_fire  = fl.alloc_req & w_alloc_valid & ~fl.stall & ~fl.flush;
    assign w_commit_next = w_commit_head + fl_ptr_t'(fl.commit_alloc);

    // Room is judged against the committed head after this cycle's commit, so a
    // tag retiring in the same cycle its slot is reclaimed can still be pushed.
    assign w_commit_occ  = w_tail - w_commit_next;
    assign w_push_ok     = (w_commit_occ < c_fl_depth);
    assign w_push        = fl.free_en & w_push_ok;

    fl_ptr_ctr #(.RESET_VAL('0)) u_spec_head (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (w_alloc_fire),
        .i_load     (fl.flush),
        .i_load_val (w_commit_next),
        .o_ptr      (w_spec_head)
    );

    fl_ptr_ctr #(.RESET_VAL('0)) u_commit_head (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (fl.commit_alloc),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_commit_head)
    );

    fl_ptr_ctr #(.RESET_VAL(c_fl_depth)) u_tail (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (w_push),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_tail)
    );

    generate
        for (genvar i = 0; i < FL_DEPTH; i++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_entry[i] <= ptag_t'(AREGS + i);
                end else if (w_push && (fl_idx(w_tail) == AREG_W'(i))) begin
                    r_entry[i] <= fl.free_tag;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (fl.free_en && !w_push_ok) begin
            r_overflow <= 1'b1;
        end
    end

    assign fl.alloc_tag    = r_entry[fl_idx(w_spec_head)];
    assign fl.alloc_valid  = w_alloc_valid;
    assign fl.free_count   = w_tail - w_spec_head;
    assign fl.overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_phys_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_phys_free_list
// Brief    : Scenario and randomized checks of phys_free_list against a FIFO model
// Revision : 1.0
// ============================================================================
module tb_phys_free_list;

    logic clk;
    logic reset;

    phys_free_list_if fl_if ();

    phys_free_list #(.PREGS(64), .AREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: unbounded counters, index = count mod 32.
    logic [5:0] m_mem [32];
    int         m_spec;
    int         m_commit;
    int         m_tail;
    bit         m_ovf;

    function automatic logic [5:0] exp_tag();
        return m_mem[m_spec % 32];
    endfunction

    function automatic logic [5:0] exp_cnt();
        return 6'(m_tail - m_spec);
    endfunction

    task automatic clear_inputs();
        fl_if.stall        = 1'b0;
        fl_if.alloc_req    = 1'b0;
        fl_if.commit_alloc = 1'b0;
        fl_if.free_en      = 1'b0;
        fl_if.free_tag     = '0;
        fl_if.flush        = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 6'(32 + i);
        m_spec   = 0;
        m_commit = 0;
        m_tail   = 32;
        m_ovf    = 1'b0;
    endtask

    // Applies the current inputs to the model, then clocks the DUT once.
    task automatic advance();
        int  cn;
        bit  fire;
        assert (!(fl_if.commit_alloc && (m_commit >= m_spec)))
            else $error("commit head would pass speculative head");
        cn   = m_commit + int'(fl_if.commit_alloc);
        fire = fl_if.alloc_req && (m_tail != m_spec) && !fl_if.stall && !fl_if.flush;
        if (fl_if.free_en) begin
            if ((m_tail - cn) < 32) begin
                m_mem[m_tail % 32] = fl_if.free_tag;
                m_tail++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (fl_if.flush) m_spec = cn;
        else if (fire)   m_spec++;
        m_commit = cn;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            fl_if.alloc_req = 1'b1;
            fl_if.free_en   = 1'b1;
            fl_if.free_tag  = 6'd3;
            advance();
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (fl_if.alloc_tag !== 6'd32) begin
            errors++; $display("FAIL reset_tag actual=%0d required=32", fl_if.alloc_tag);
        end
        checks++;
        if (fl_if.free_count !== 6'd32) begin
            errors++; $display("FAIL reset_count actual=%0d required=32", fl_if.free_count);
        end
        checks++;
        if (fl_if.alloc_valid !== 1'b1 || fl_if.overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags actual valid=%b ovf=%b required valid=1 ovf=0",
                     fl_if.alloc_valid, fl_if.overflow_err);
        end
        do_reset();
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            fl_if.alloc_req = 1'b1;
            @(negedge clk);
            checks++;
            if (fl_if.alloc_tag !== 6'(32 + i) || fl_if.alloc_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_tag[%0d] actual=%0d/%b required=%0d/1",
                         i, fl_if.alloc_tag, fl_if.alloc_valid, 32 + i);
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (fl_if.free_count !== 6'd0 || fl_if.alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty actual cnt=%0d valid=%b required cnt=0 valid=0",
                     fl_if.free_count, fl_if.alloc_valid);
        end
        fl_if.alloc_req = 1'b1;
        advance();
        @(negedge clk);
        checks++;
        if (fl_if.free_count !== 6'd0) begin
            errors++; $display("FAIL drain_extra_req actual cnt=%0d required=0", fl_if.free_count);
        end
    endtask

    task automatic test_free_from_empty();
        for (int i = 0; i < 32; i++) begin
            fl_if.commit_alloc = 1'b1;
            advance();
        end
        fl_if.free_en  = 1'b1;
        fl_if.free_tag = 6'd5;
        @(negedge clk);
        checks++;
        if (fl_if.alloc_valid !== 1'b0) begin
            errors++; $display("FAIL free_no_bypass actual valid=%b required=0", fl_if.alloc_valid);
        end
        advance();
        @(negedge clk);
        checks++;
        if (fl_if.alloc_tag !== 6'd5 || fl_if.free_count !== 6'd1) begin
            errors++;
            $display("FAIL free_from_empty actual tag=%0d cnt=%0d required tag=5 cnt=1",
                     fl_if.alloc_tag, fl_if.free_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin fl_if.alloc_req = 1'b1; advance(); end
        for (int i = 0; i < 2; i++) begin fl_if.commit_alloc = 1'b1; advance(); end
        fl_if.flush     = 1'b1;
        fl_if.alloc_req = 1'b1;
        advance();
        @(negedge clk);
        checks++;
        if (fl_if.alloc_tag !== 6'd34 || fl_if.free_count !== 6'd30) begin
            errors++;
            $display("FAIL flush_rollback actual tag=%0d cnt=%0d required tag=34 cnt=30",
                     fl_if.alloc_tag, fl_if.free_count);
        end
    endtask

    task automatic test_flush_commit_free();
        do_reset();
        for (int i = 0; i < 3; i++) begin fl_if.alloc_req = 1'b1; advance(); end
        fl_if.flush        = 1'b1;
        fl_if.commit_alloc = 1'b1;
        fl_if.free_en      = 1'b1;
        fl_if.free_tag     = 6'd7;
        fl_if.alloc_req    = 1'b1;
        advance();
        @(negedge clk);
        checks++;
        if (fl_if.alloc_tag !== 6'd33 || fl_if.free_count !== 6'd32) begin
            errors++;
            $display("FAIL flush_commit_free actual tag=%0d cnt=%0d required tag=33 cnt=32",
                     fl_if.alloc_tag, fl_if.free_count);
        end
        for (int i = 0; i < 31; i++) begin fl_if.alloc_req = 1'b1; advance(); end
        @(negedge clk);
        checks++;
        if (fl_if.alloc_tag !== 6'd7 || fl_if.free_count !== 6'd1) begin
            errors++;
            $display("FAIL flush_free_landed actual tag=%0d cnt=%0d required tag=7 cnt=1",
                     fl_if.alloc_tag, fl_if.free_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        fl_if.alloc_req = 1'b1;
        advance();
        fl_if.commit_alloc = 1'b1;
        advance();
        for (int i = 0; i < 3; i++) begin
            fl_if.stall     = 1'b1;
            fl_if.alloc_req = 1'b1;
            if (i == 1) begin
                fl_if.free_en  = 1'b1;
                fl_if.free_tag = 6'd9;
            end
            @(negedge clk);
            checks++;
            if (fl_if.alloc_tag !== 6'd33) begin
                errors++; $display("FAIL stall_hold[%0d] actual=%0d required=33", i, fl_if.alloc_tag);
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (fl_if.free_count !== 6'd32 || fl_if.free_count !== exp_cnt()) begin
            errors++;
            $display("FAIL stall_free actual cnt=%0d required=32", fl_if.free_count);
        end
    endtask

    task automatic test_wrap_overflow();
        logic [5:0] tag;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            tag = 6'(32 + (k % 32));
            fl_if.alloc_req = 1'b1;
            @(negedge clk);
            checks++;
            if (fl_if.alloc_tag !== tag || fl_if.alloc_tag !== exp_tag()) begin
                errors++;
                $display("FAIL wrap_order[%0d] actual=%0d required=%0d", k, fl_if.alloc_tag, tag);
            end
            advance();
            fl_if.commit_alloc = 1'b1;
            fl_if.free_en      = 1'b1;
            fl_if.free_tag     = tag;
            advance();
        end
        @(negedge clk);
        checks++;
        if (fl_if.free_count !== 6'd32 || fl_if.overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full actual cnt=%0d ovf=%b required cnt=32 ovf=0",
                     fl_if.free_count, fl_if.overflow_err);
        end
        fl_if.free_en  = 1'b1;
        fl_if.free_tag = 6'd1;
        advance();
        @(negedge clk);
        checks++;
        if (fl_if.overflow_err !== 1'b1 || fl_if.free_count !== 6'd32) begin
            errors++;
            $display("FAIL overflow_set actual ovf=%b cnt=%0d required ovf=1 cnt=32",
                     fl_if.overflow_err, fl_if.free_count);
        end
        repeat (5) begin fl_if.alloc_req = 1'b1; advance(); end
        @(negedge clk);
        checks++;
        if (fl_if.overflow_err !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky actual=%b required=1", fl_if.overflow_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            fl_if.stall        = ($urandom % 4) == 0;
            fl_if.alloc_req    = ($urandom % 4) != 0;
            fl_if.commit_alloc = (m_commit < m_spec) && (($urandom % 2) == 0);
            fl_if.free_en      = ($urandom % 3) == 0;
            fl_if.free_tag     = 6'($urandom);
            fl_if.flush        = ($urandom % 20) == 0;
            @(negedge clk);
            checks++;
            if (fl_if.alloc_valid !== (m_tail != m_spec) || fl_if.free_count !== exp_cnt()
                || fl_if.overflow_err !== m_ovf
                || ((m_tail != m_spec) && fl_if.alloc_tag !== exp_tag())) begin
                errors++;
                $display("FAIL random[%0d] actual v=%b t=%0d c=%0d o=%b required v=%b t=%0d c=%0d o=%b",
                         c, fl_if.alloc_valid, fl_if.alloc_tag, fl_if.free_count, fl_if.overflow_err,
                         m_tail != m_spec, exp_tag(), exp_cnt(), m_ovf);
            end
            advance();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        model_reset();
        do_reset();
        test_reset();
        test_drain();
        test_free_from_empty();
        test_flush();
        test_flush_commit_free();
        test_stall();
        test_wrap_overflow();
        test_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
